phase_seq: RTL and testbench

- Instruction-phase sequencer for the cpu15 core.
- Generates the per-phase clock strobes CLK_FT, CLK_DC, CLK_EX and CLK_WB that drive the fetch, register-decode, execute and writeback stages from a single master clock.
- Supports free-run and single-step, memory wait stalls, and HLT detection from decode.
- Keeps a retired-instruction counter.

---
 rtl/cpu15_pkg.sv | 18 +
 rtl/phase_seq.sv | 145 ++++++++++++++
 tb/tb_phase_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu15_pkg.sv
// rtl/cpu15_pkg.sv - shared state and phase encodings for the cpu15 instruction sequencer
package cpu15_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FT   = 3'd1,
    ST_DC   = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [1:0] PH_FT = 2'd0;
  localparam logic [1:0] PH_DC = 2'd1;
  localparam logic [1:0] PH_EX = 2'd2;
  localparam logic [1:0] PH_WB = 2'd3;

endpackage

// File: rtl/phase_seq.sv
// rtl/phase_seq.sv - cpu15 phase sequencer: FT/DC/EX/WB strobes, stalls, HLT, retire count
// Optional stall counter output enabled by defining PHASE_SEQ_STALL_CNT_EN.
module phase_seq
  import cpu15_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             WAIT_REQ,
  input  logic             HALT_REQ,
  output logic             CLK_FT,
  output logic             CLK_DC,
  output logic             CLK_EX,
  output logic             CLK_WB,
  output logic [1:0]       PHASE,
  output logic             BUSY,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSN_CNT
`ifdef PHASE_SEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT
`endif
);

  state_t           r_state;
  logic             r_step_mode;
  logic             r_ft;
  logic             r_dc;
  logic             r_ex;
  logic             r_wb;
  logic [1:0]       r_phase;
  logic             r_busy;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;

  // Strobes default low and are set only on the edge that enters a state,
  // so a stalled phase never repeats its strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_step_mode <= 1'b0;
      r_ft        <= 1'b0;
      r_dc        <= 1'b0;
      r_ex        <= 1'b0;
      r_wb        <= 1'b0;
      r_phase     <= PH_FT;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_ft <= 1'b0;
      r_dc <= 1'b0;
      r_ex <= 1'b0;
      r_wb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (RUN || STEP) begin
            r_step_mode <= ~RUN;
            r_state     <= ST_FT;
            r_ft        <= 1'b1;
            r_phase     <= PH_FT;
            r_busy      <= 1'b1;
          end
        end
        ST_FT: begin
          if (!WAIT_REQ) begin
            r_state <= ST_DC;
            r_dc    <= 1'b1;
            r_phase <= PH_DC;
          end
        end
        ST_DC: begin
          if (HALT_REQ) begin
            r_state  <= ST_HALT;
            r_phase  <= PH_FT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_EX;
            r_ex    <= 1'b1;
            r_phase <= PH_EX;
          end
        end
        ST_EX: begin
          if (!WAIT_REQ) begin
            r_state <= ST_WB;
            r_wb    <= 1'b1;
            r_phase <= PH_WB;
          end
        end
        ST_WB: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_step_mode || !RUN) begin
            r_state <= ST_IDLE;
            r_phase <= PH_FT;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_FT;
            r_ft    <= 1'b1;
            r_phase <= PH_FT;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_phase  <= PH_FT;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHASE_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall;
  logic             w_stalling;

  assign w_stalling = WAIT_REQ && ((r_state == ST_FT) || (r_state == ST_EX));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall <= '0;
    end else if (w_stalling && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign STALL_CNT = r_stall;
`endif

  assign CLK_FT   = r_ft;
  assign CLK_DC   = r_dc;
  assign CLK_EX   = r_ex;
  assign CLK_WB   = r_wb;
  assign PHASE    = r_phase;
  assign BUSY     = r_busy;
  assign HALTED   = r_halted;
  assign INSN_CNT = r_cnt;

endmodule

// File: tb/tb_phase_seq.sv
// tb/tb_phase_seq.sv - randomized self-checking bench for phase_seq against an instruction-level model
module tb_phase_seq;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        wreq;
  logic        hreq;

  logic        ft, dc, ex, wb, busy, halted;
  logic [1:0]  phase;
  logic [15:0] cnt;
  logic        ft4, dc4, ex4, wb4, busy4, halted4;
  logic [1:0]  phase4;
  logic [3:0]  cnt4;
`ifdef PHASE_SEQ_STALL_CNT_EN
  logic [15:0] stall;
  logic [3:0]  stall4;
`endif

  phase_seq #(.CNT_W(16)) dut (
    .CLK(clk), .RESET_N(rst_n), .RUN(run), .STEP(step), .WAIT_REQ(wreq), .HALT_REQ(hreq),
    .CLK_FT(ft), .CLK_DC(dc), .CLK_EX(ex), .CLK_WB(wb), .PHASE(phase), .BUSY(busy),
    .HALTED(halted), .INSN_CNT(cnt)
`ifdef PHASE_SEQ_STALL_CNT_EN
    , .STALL_CNT(stall)
`endif
  );

  phase_seq #(.CNT_W(4)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .RUN(run), .STEP(step), .WAIT_REQ(wreq), .HALT_REQ(hreq),
    .CLK_FT(ft4), .CLK_DC(dc4), .CLK_EX(ex4), .CLK_WB(wb4), .PHASE(phase4), .BUSY(busy4),
    .HALTED(halted4), .INSN_CNT(cnt4)
`ifdef PHASE_SEQ_STALL_CNT_EN
    , .STALL_CNT(stall4)
`endif
  );

  wire [8:0] act  = {ft, dc, ex, wb, phase, busy, halted};
  wire [8:0] act4 = {ft4, dc4, ex4, wb4, phase4, busy4, halted4};

  int total = 0;
  int bad   = 0;

  // Model: m_ph = -1 idle, 0..3 = FT/DC/EX/WB, 4 = halted; m_new marks first cycle of a phase.
  int m_ph;
  bit m_new;
  bit m_step;
  int m_cnt;
  int m_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ph = -1; m_new = 0; m_step = 0; m_cnt = 0; m_stall = 0;
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit w, input bit h);
    m_new = 0;
    if (m_ph == -1) begin
      if (r || s) begin m_step = !r; m_ph = 0; m_new = 1; end
    end else if (m_ph == 4) begin
    end else if ((m_ph == 0 || m_ph == 2) && w) begin
      if (m_stall < 65535) m_stall++;
    end else if (m_ph == 1 && h) begin
      m_ph = 4;
    end else if (m_ph == 3) begin
      m_cnt++;
      if (m_step || !r) m_ph = -1;
      else begin m_ph = 0; m_new = 1; end
    end else begin
      m_ph++; m_new = 1;
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] s;
    logic [1:0] p;
    bit         active;
    active = (m_ph >= 0) && (m_ph <= 3);
    s = (m_new && active) ? (4'b1000 >> m_ph) : 4'b0000;
    p = active ? m_ph[1:0] : 2'd0;
    return {s, p, active, (m_ph == 4)};
  endfunction

  task automatic cycle(input bit r, input bit s, input bit w, input bit h);
    run = r; step = s; wreq = w; hreq = h;
    @(posedge clk);
    model_step(r, s, w, h);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    run = 0; step = 0; wreq = 0; hreq = 0;
    do_reset();
    total++;
    if (act !== 9'd0 || cnt !== 16'd0) begin
      bad++; $display("FAIL reset: got vec=%b cnt=%0d want vec=0 cnt=0", act, cnt);
    end
    total++;
    if (act4 !== 9'd0 || cnt4 !== 4'd0) begin
      bad++; $display("FAIL reset_w4: got vec=%b cnt=%0d want 0", act4, cnt4);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 13; i++) begin
      cycle(1, 0, 0, 0);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL free_run cyc %0d: got %b want %b", i, act, exp_vec());
      end
      total++;
      if ($countones({ft, dc, ex, wb}) != 1) begin
        bad++; $display("FAIL free_run_onehot cyc %0d: got %b want one strobe", i, {ft, dc, ex, wb});
      end
    end
    total++;
    if (cnt !== 16'd3) begin
      bad++; $display("FAIL free_run_cnt: got %0d want 3", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      total++;
      if (act !== exp_vec() || cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL free_run_drain cyc %0d: got %b/%0d want %b/%0d", i, act, cnt, exp_vec(), m_cnt);
      end
    end
  endtask

  task automatic test_step();
    bit s_seq [6] = '{1, 0, 0, 1, 0, 0};
    int base = m_cnt;
    for (int i = 0; i < 6; i++) begin
      cycle(0, s_seq[i], 0, 0);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL step cyc %0d: got %b want %b", i, act, exp_vec());
      end
    end
    total++;
    if (cnt !== 16'(base + 1) || busy !== 1'b0) begin
      bad++; $display("FAIL step_once: got cnt=%0d busy=%b want cnt=%0d busy=0", cnt, busy, base + 1);
    end
  endtask

  task automatic test_wait();
    bit r_seq [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit w_seq [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    int n_ft = 0, n_dc = 0, n_ex = 0, n_wb = 0, n_busy = 0;
    int stall0 = m_stall;
`ifdef PHASE_SEQ_STALL_CNT_EN
    logic [15:0] hw_stall0 = stall;
`endif
    for (int i = 0; i < 10; i++) begin
      cycle(r_seq[i], 0, w_seq[i], 0);
      n_ft += ft; n_dc += dc; n_ex += ex; n_wb += wb; n_busy += busy;
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL wait cyc %0d: got %b want %b", i, act, exp_vec());
      end
    end
    total++;
    if (n_ft != 1 || n_dc != 1 || n_ex != 1 || n_wb != 1) begin
      bad++; $display("FAIL wait_strobes: got ft=%0d dc=%0d ex=%0d wb=%0d want 1 each", n_ft, n_dc, n_ex, n_wb);
    end
    total++;
    if (n_busy != 9) begin
      bad++; $display("FAIL wait_len: got %0d want 9", n_busy);
    end
`ifdef PHASE_SEQ_STALL_CNT_EN
    total++;
    if (stall - hw_stall0 !== 16'(m_stall - stall0) || (m_stall - stall0) != 5) begin
      bad++; $display("FAIL wait_stall: got delta %0d want 5", stall - hw_stall0);
    end
`endif
  endtask

  task automatic test_halt();
    int base = m_cnt;
    int n_exwb = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    total++;
    if (act !== exp_vec() || halted !== 1'b1) begin
      bad++; $display("FAIL halt_enter: got %b want %b", act, exp_vec());
    end
    for (int i = 0; i < 10; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      n_exwb += ex + wb;
      total++;
      if (act !== exp_vec() || halted !== 1'b1) begin
        bad++; $display("FAIL halt_sticky cyc %0d: got %b want %b", i, act, exp_vec());
      end
    end
    total++;
    if (n_exwb != 0 || cnt !== 16'(base)) begin
      bad++; $display("FAIL halt_quiet: got exwb=%0d cnt=%0d want 0/%0d", n_exwb, cnt, base);
    end
    run = 0; step = 0; wreq = 0; hreq = 0;
    do_reset();
    total++;
    if (act !== 9'd0 || cnt !== 16'd0) begin
      bad++; $display("FAIL halt_reset: got %b cnt=%0d want 0", act, cnt);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 69; i++) begin
      cycle(1, 0, 0, 0);
      total++;
      if (act4 !== exp_vec() || cnt4 !== 4'(m_cnt) || cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL wrap cyc %0d: got %b/%0d want %b/%0d", i, act4, cnt4, exp_vec(), m_cnt);
      end
    end
    total++;
    if (cnt4 !== 4'd1 || cnt !== 16'd17) begin
      bad++; $display("FAIL wrap_value: got w4=%0d w16=%0d want 1/17", cnt4, cnt);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    total++;
    if (ex !== 1'b1 || phase !== 2'd2) begin
      bad++; $display("FAIL async_pre: got ex=%b phase=%0d want 1/2", ex, phase);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (act !== 9'd0 || act4 !== 9'd0 || cnt !== 16'd0) begin
      bad++; $display("FAIL async_reset: got %b/%b cnt=%0d want 0", act, act4, cnt);
    end
    model_reset();
    run = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (act !== 9'd0) begin
      bad++; $display("FAIL async_hold: got %b want 0", act);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_ph == 4 && $urandom_range(0, 3) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      total++;
      if (act !== exp_vec() || cnt !== 16'(m_cnt) || cnt4 !== 4'(m_cnt)) begin
        bad++; $display("FAIL random cyc %0d: got %b/%0d want %b/%0d", i, act, cnt, exp_vec(), m_cnt);
      end
`ifdef PHASE_SEQ_STALL_CNT_EN
      total++;
      if (stall !== 16'(m_stall)) begin
        bad++; $display("FAIL random_stall cyc %0d: got %0d want %0d", i, stall, m_stall);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b1;
    run = 0; step = 0; wreq = 0; hreq = 0;
    model_reset();
    test_reset();
    test_free_run();
    test_step();
    test_wait();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
